// File: rtl/pe_mac.sv
// pe_mac: output-stationary MAC processing element for a 2-D systolic array.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   in_a/in_a_vld, in_b/in_b_vld operands from left/upper neighbours
//   clear, load                  accumulator clear, drain load strobe
//   psum_in/psum_in_vld          drain chain input from upper neighbour
//   out_a/out_a_vld              registered in_a to right neighbour
//   out_b/out_b_vld              registered in_b to lower neighbour
//   psum_out/psum_vld            drain chain output to lower neighbour
//   acc_out, ovf                 accumulator and sticky overflow flag
module pe_mac #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 20,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_a,
    input  logic              in_a_vld,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_b_vld,
    input  logic              clear,
    input  logic              load,
    input  logic [ACC_W-1:0]  psum_in,
    input  logic              psum_in_vld,
    output logic [DATA_W-1:0] out_a,
    output logic              out_a_vld,
    output logic [DATA_W-1:0] out_b,
    output logic              out_b_vld,
    output logic [ACC_W-1:0]  psum_out,
    output logic              psum_vld,
    output logic [ACC_W-1:0]  acc_out,
    output logic              ovf
);
    localparam int PW = 2 * DATA_W;
    localparam logic SGN = SIGNED != 0;
    localparam logic SAT = SATURATE != 0;

    logic             fire, of;
    logic [PW-1:0]    a_ext, b_ext, prod;
    logic [ACC_W:0]   base, term, sum;
    logic [ACC_W-1:0] lim, res;

    // Operands are extended to 2*DATA_W so the low half of the product is
    // correct for both signed and unsigned interpretation.
    // A load starts a fresh result, so the old accumulator is not summed.
    always_comb begin
        fire  = in_a_vld & in_b_vld;
        a_ext = {{DATA_W{SGN & in_a[DATA_W-1]}}, in_a};
        b_ext = {{DATA_W{SGN & in_b[DATA_W-1]}}, in_b};
        prod  = a_ext * b_ext;
        term  = fire ? {{(ACC_W + 1 - PW){SGN & prod[PW-1]}}, prod} : '0;
        base  = load ? '0 : {SGN & acc_out[ACC_W-1], acc_out};
        sum   = base + term;
        of    = SGN ? sum[ACC_W] ^ sum[ACC_W-1] : sum[ACC_W];
        lim   = SGN ? {sum[ACC_W], {(ACC_W - 1){~sum[ACC_W]}}} : '1;
        res   = (of && SAT) ? lim : sum[ACC_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_a     <= '0;
            out_a_vld <= 1'b0;
            out_b     <= '0;
            out_b_vld <= 1'b0;
            psum_out  <= '0;
            psum_vld  <= 1'b0;
            acc_out   <= '0;
            ovf       <= 1'b0;
        end else begin
            out_a     <= in_a;
            out_a_vld <= in_a_vld;
            out_b     <= in_b;
            out_b_vld <= in_b_vld;
            psum_out  <= load ? acc_out : psum_in;
            psum_vld  <= load | psum_in_vld;
            if (clear) begin
                acc_out <= '0;
                ovf     <= 1'b0;
            end else if (load) begin
                acc_out <= res;
                ovf     <= of;
            end else if (fire) begin
                acc_out <= res;
                ovf     <= ovf | of;
            end
        end
    end
endmodule

// File: tb/tb_pe_mac.sv
// tb_pe_mac: four single PEs with different parameter sets share one stimulus
// stream and are checked every cycle against an arithmetic model; a 3-deep
// column checks the drain chain; literal expectations pin the model.
module tb_pe_mac;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic [7:0]  a = '0, b = '0;
    logic        av = 1'b0, bv = 1'b0, clr = 1'b0, ld = 1'b0;
    logic [19:0] psi = '0;
    logic        psiv = 1'b0;
    bit          run = 1'b0;
    int          tests = 0, fails = 0;

    logic [7:0]  oa[4], ob[4];
    logic        oav[4], obv[4], pv[4], ov[4];
    logic [19:0] ac0, ac1, po0, po1;
    logic [15:0] ac2, ac3, po2, po3;
    logic [19:0] acv[4], pov[4];

    always_comb begin
        acv[0] = ac0; acv[1] = ac1; acv[2] = {4'b0, ac2}; acv[3] = {4'b0, ac3};
        pov[0] = po0; pov[1] = po1; pov[2] = {4'b0, po2}; pov[3] = {4'b0, po3};
    end

    pe_mac #(.DATA_W(8), .ACC_W(20), .SIGNED(0), .SATURATE(1)) u0 (
        .clk(clk), .reset_n(reset_n), .in_a(a), .in_a_vld(av), .in_b(b), .in_b_vld(bv),
        .clear(clr), .load(ld), .psum_in(psi), .psum_in_vld(psiv),
        .out_a(oa[0]), .out_a_vld(oav[0]), .out_b(ob[0]), .out_b_vld(obv[0]),
        .psum_out(po0), .psum_vld(pv[0]), .acc_out(ac0), .ovf(ov[0]));
    pe_mac #(.DATA_W(8), .ACC_W(20), .SIGNED(1), .SATURATE(1)) u1 (
        .clk(clk), .reset_n(reset_n), .in_a(a), .in_a_vld(av), .in_b(b), .in_b_vld(bv),
        .clear(clr), .load(ld), .psum_in(psi), .psum_in_vld(psiv),
        .out_a(oa[1]), .out_a_vld(oav[1]), .out_b(ob[1]), .out_b_vld(obv[1]),
        .psum_out(po1), .psum_vld(pv[1]), .acc_out(ac1), .ovf(ov[1]));
    pe_mac #(.DATA_W(8), .ACC_W(16), .SIGNED(0), .SATURATE(1)) u2 (
        .clk(clk), .reset_n(reset_n), .in_a(a), .in_a_vld(av), .in_b(b), .in_b_vld(bv),
        .clear(clr), .load(ld), .psum_in(psi[15:0]), .psum_in_vld(psiv),
        .out_a(oa[2]), .out_a_vld(oav[2]), .out_b(ob[2]), .out_b_vld(obv[2]),
        .psum_out(po2), .psum_vld(pv[2]), .acc_out(ac2), .ovf(ov[2]));
    pe_mac #(.DATA_W(8), .ACC_W(16), .SIGNED(0), .SATURATE(0)) u3 (
        .clk(clk), .reset_n(reset_n), .in_a(a), .in_a_vld(av), .in_b(b), .in_b_vld(bv),
        .clear(clr), .load(ld), .psum_in(psi[15:0]), .psum_in_vld(psiv),
        .out_a(oa[3]), .out_a_vld(oav[3]), .out_b(ob[3]), .out_b_vld(obv[3]),
        .psum_out(po3), .psum_vld(pv[3]), .acc_out(ac3), .ovf(ov[3]));

    // 3-deep column, row 0 on top; bottom output is row 2.
    logic [7:0]  ca[3] = '{default: '0}, cb[3] = '{default: '0};
    logic        cav[3] = '{default: 1'b0}, cbv[3] = '{default: 1'b0};
    logic        cclr = 1'b0, cld = 1'b0;
    logic [19:0] cp[3], cacc[3];
    logic        cpv[3], covf[3], coav[3], cobv[3];
    logic [7:0]  coa[3], cob[3];

    for (genvar i = 0; i < 3; i++) begin : g_col
        pe_mac u (
            .clk(clk), .reset_n(reset_n), .in_a(ca[i]), .in_a_vld(cav[i]),
            .in_b(cb[i]), .in_b_vld(cbv[i]), .clear(cclr), .load(cld),
            .psum_in(i == 0 ? 20'd0 : cp[(i == 0) ? 0 : i-1]),
            .psum_in_vld(i == 0 ? 1'b0 : cpv[(i == 0) ? 0 : i-1]),
            .out_a(coa[i]), .out_a_vld(coav[i]), .out_b(cob[i]), .out_b_vld(cobv[i]),
            .psum_out(cp[i]), .psum_vld(cpv[i]), .acc_out(cacc[i]), .ovf(covf[i]));
    end

    // Model: accumulator kept as a mathematical integer per parameter set.
    bit     msg[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    bit     msat[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int     mw[4]   = '{20, 20, 16, 16};
    longint m_acc[4], m_po[4];
    bit     m_ovf[4], m_pv[4];
    logic [7:0] m_oa, m_ob;
    bit     m_oav, m_obv;

    function automatic longint mask(input int k);
        return (longint'(1) <<< mw[k]) - 1;
    endfunction

    function automatic longint ival(input logic [7:0] x, input bit s);
        return s ? longint'($signed(x)) : longint'(x);
    endfunction

    function automatic longint fit(input longint v, input int k, output bit o);
        longint mx, mn, r;
        mx = msg[k] ? (longint'(1) <<< (mw[k] - 1)) - 1 : mask(k);
        mn = msg[k] ? -(longint'(1) <<< (mw[k] - 1)) : 0;
        o = (v > mx) || (v < mn);
        if (!o) return v;
        if (msat[k]) return (v > mx) ? mx : mn;
        r = v & mask(k);
        if (msg[k] && r > mx) r -= (longint'(1) <<< mw[k]);
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 4; k++) begin
                m_acc[k] = 0; m_po[k] = 0; m_ovf[k] = 0; m_pv[k] = 0;
            end
            m_oa = '0; m_ob = '0; m_oav = 0; m_obv = 0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                longint p;
                bit o;
                p = (av && bv) ? ival(a, msg[k]) * ival(b, msg[k]) : 0;
                m_po[k] = ld ? (m_acc[k] & mask(k)) : (longint'(psi) & mask(k));
                m_pv[k] = ld || psiv;
                if (clr) begin
                    m_acc[k] = 0; m_ovf[k] = 0;
                end else if (ld) begin
                    m_acc[k] = fit(p, k, o); m_ovf[k] = o;
                end else if (av && bv) begin
                    m_acc[k] = fit(m_acc[k] + p, k, o); m_ovf[k] = m_ovf[k] || o;
                end
            end
            m_oa = a; m_ob = b; m_oav = av; m_obv = bv;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (run) begin
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("acc%0d", k), 64'(acv[k]), 64'(m_acc[k] & mask(k)));
            chk($sformatf("ovf%0d", k), 64'(ov[k]), 64'(m_ovf[k]));
            chk($sformatf("psum%0d", k), 64'(pov[k]), 64'(m_po[k]));
            chk($sformatf("psum_vld%0d", k), 64'(pv[k]), 64'(m_pv[k]));
            chk($sformatf("out_a%0d", k), 64'(oa[k]), 64'(m_oa));
            chk($sformatf("out_b%0d", k), 64'(ob[k]), 64'(m_ob));
            chk($sformatf("out_a_vld%0d", k), 64'(oav[k]), 64'(m_oav));
            chk($sformatf("out_b_vld%0d", k), 64'(obv[k]), 64'(m_obv));
        end
    end

    task automatic step(input logic [7:0] ta, tb, input logic tav, tbv, tclr, tld);
        a = ta; b = tb; av = tav; bv = tbv; clr = tclr; ld = tld;
        psi = 20'($urandom); psiv = 1'($urandom);
        @(posedge clk);
        #1;
    endtask

    logic [7:0] pa[6] = '{8'd2, 8'd2, 8'd2, 8'd3, 8'd3, 8'd3};
    logic [7:0] pb[6] = '{8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3};
    int         ex[6] = '{2, 6, 12, 15, 21, 30};

    initial begin
        #12;
        chk("rst_acc", 64'(acv[0]), 0);
        chk("rst_psum_vld", 64'(pv[0]), 0);
        @(negedge clk);
        reset_n = 1'b1;
        run = 1'b1;

        for (int i = 0; i < 6; i++) begin
            step(pa[i], pb[i], 1, 1, 0, 0);
            chk("stream_acc", 64'(acv[0]), 64'(ex[i]));
            chk("stream_out_a", 64'(oa[0]), 64'(pa[i]));
            chk("stream_out_b", 64'(ob[0]), 64'(pb[i]));
        end
        chk("stream_ovf", 64'(ov[0]), 0);

        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            step(pa[i], pb[i], 1, logic'(i != 2), 0, 0);
            if (i == 2) chk("gap_out_b_vld_lo", 64'(obv[0]), 0);
            if (i == 3) chk("gap_out_b_vld_hi", 64'(obv[0]), 1);
        end
        chk("gap_acc", 64'(acv[0]), 24);

        step(0, 0, 0, 0, 1, 0);
        step(8'h80, 8'h80, 1, 1, 0, 0);
        chk("signed_acc1", 64'(acv[1]), 16384);
        step(8'hFD, 8'h05, 1, 1, 0, 0);
        chk("signed_acc2", 64'(acv[1]), 16369);

        step(0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 5; i++) begin
            step(8'hFF, 8'hFF, 1, 1, 0, 0);
            if (i == 1) chk("sat_ovf_first", 64'(ov[2]), 0);
            if (i == 2) chk("sat_acc_second", 64'(acv[2]), 65535);
            if (i == 2) chk("sat_ovf_second", 64'(ov[2]), 1);
        end
        chk("sat_acc_final", 64'(acv[2]), 65535);
        chk("wrap_acc_final", 64'(acv[3]), 62981);
        chk("wrap_ovf", 64'(ov[3]), 1);
        step(0, 0, 0, 0, 1, 0);
        chk("clear_acc", 64'(acv[2]), 0);
        chk("clear_ovf", 64'(ov[2]), 0);

        step(8'd5, 8'd5, 1, 1, 0, 0);
        step(8'd2, 8'd2, 1, 1, 0, 1);
        chk("load_psum", 64'(pov[0]), 25);
        chk("load_psum_vld", 64'(pv[0]), 1);
        chk("load_acc", 64'(acv[0]), 4);
        step(0, 0, 0, 0, 0, 1);
        chk("reload_psum", 64'(pov[0]), 4);
        chk("reload_acc", 64'(acv[0]), 0);
        step(0, 0, 0, 0, 1, 1);
        step(8'd1, 8'd1, 1, 1, 0, 0);

        cclr = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        cclr = 1'b0;
        ca = '{8'd7, 8'd11, 8'd13}; cb = '{8'd1, 8'd1, 8'd1};
        cav = '{1'b1, 1'b1, 1'b1}; cbv = '{1'b1, 1'b1, 1'b1};
        step(0, 0, 0, 0, 0, 0);
        cav = '{1'b0, 1'b0, 1'b0}; cbv = '{1'b0, 1'b0, 1'b0};
        chk("col_acc_bottom", 64'(cacc[2]), 13);
        chk("col_acc_top", 64'(cacc[0]), 7);
        cld = 1'b1; ca[2] = 8'd2; cb[2] = 8'd2; cav[2] = 1'b1; cbv[2] = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        cld = 1'b0; cav[2] = 1'b0; cbv[2] = 1'b0;
        chk("col_drain0", 64'(cp[2]), 13);
        chk("col_drain0_vld", 64'(cpv[2]), 1);
        chk("col_acc_after_load", 64'(cacc[2]), 4);
        step(0, 0, 0, 0, 0, 0);
        chk("col_drain1", 64'(cp[2]), 11);
        chk("col_drain1_vld", 64'(cpv[2]), 1);
        step(0, 0, 0, 0, 0, 0);
        chk("col_drain2", 64'(cp[2]), 7);
        chk("col_drain2_vld", 64'(cpv[2]), 1);
        step(0, 0, 0, 0, 0, 0);
        chk("col_drain_end_vld", 64'(cpv[2]), 0);

        step(8'd4, 8'd4, 1, 1, 0, 0);
        cld = 1'b1;
        step(8'd4, 8'd4, 1, 1, 0, 0);
        cld = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async_acc", 64'(acv[0]), 0);
        chk("async_out_a_vld", 64'(oav[0]), 0);
        chk("async_out_a", 64'(oa[0]), 0);
        chk("async_col_psum", 64'(cp[2]), 0);
        chk("async_col_psum_vld", 64'(cpv[2]), 0);
        chk("async_col_acc", 64'(cacc[0]), 0);
        @(negedge clk);
        reset_n = 1'b1;
        step(8'd2, 8'd1, 1, 1, 0, 0);
        chk("restart_acc", 64'(acv[0]), 2);
        step(8'd3, 8'd3, 1, 1, 0, 0);
        chk("restart_acc2", 64'(acv[0]), 11);
        chk("restart_col_vld", 64'(cpv[2]), 0);
        step(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        run = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pe_mac.md
# pe_mac

Parametrised output-stationary multiply-accumulate processing element, the successor to the fixed 8-bit `pe`. It is tiled into a 2-D systolic array. Operands `a` and `b` are forwarded right and down through registers, each with its own valid bit. A local accumulator sums products, with optional signed arithmetic and saturation. A load/shift drain chain unloads results down each column without stalling accumulation.

## Interface
Parameters:
- DATA_W, 8, operand width of in_a / in_b
- ACC_W, 20, accumulator and partial-sum width; must be ≥ 2*DATA_W
- SIGNED, 0, 1 = two's-complement operands and accumulator; 0 = unsigned
- SATURATE, 1, 1 = clamp accumulator on overflow; 0 = wrap modulo 2^ACC_W

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_a  in  DATA_W  row operand from the left neighbour
- in_a_vld  in  1  in_a valid
- in_b  in  DATA_W  column operand from the upper neighbour
- in_b_vld  in  1  in_b valid
- clear  in  1  synchronous accumulator clear
- load  in  1  drain load strobe, broadcast to the whole array
- psum_in  in  ACC_W  drain chain input from the upper neighbour
- psum_in_vld  in  1  psum_in valid
- out_a / out_a_vld  out  DATA_W / 1  registered in_a / in_a_vld, to the right neighbour
- out_b / out_b_vld  out  DATA_W / 1  registered in_b / in_b_vld, to the lower neighbour
- psum_out / psum_vld  out  ACC_W / 1  drain chain output to the lower neighbour
- acc_out  out  ACC_W  current accumulator register
- ovf  out  1  sticky overflow flag

## Operation
- Reset (reset_n=0, async): every output register and the accumulator go to 0, including out_a, out_b, both forwarding valids, psum_out, psum_vld, acc_out and ovf.
- Forwarding: every cycle, out_a ← in_a, out_a_vld ← in_a_vld, out_b ← in_b, out_b_vld ← in_b_vld. Data is forwarded even when its valid is 0.
- MAC fire: fire = in_a_vld & in_b_vld.
  - Product is DATA_W×DATA_W → 2*DATA_W bits; signed or unsigned per SIGNED.
  - Product is extended (sign or zero) to ACC_W+1 bits, then added to acc.
- Overflow:
  - SATURATE=1: the result clamps to the max/min representable ACC_W value and ovf is set.
  - SATURATE=0: the result wraps; ovf is still set on overflow.
  - Unsigned mode: min is 0 and only the upper clamp applies.
- Next accumulator value, in priority order:
  1. clear: acc ← 0, ovf ← 0; any product this cycle is discarded.
  2. load: acc ← (fire ? product : 0); ovf ← overflow of that term only. The product starts the next result.
  3. fire: acc ← sat/wrap(acc + product).
  4. Otherwise acc holds.
- Drain chain:
  - load=1: psum_out ← acc (pre-update value), psum_vld ← 1.
  - load=0: psum_out ← psum_in, psum_vld ← psum_in_vld (pure shift).
  - load & clear together: psum_out still captures the old acc; then acc ← 0.
- Column behaviour: with load broadcast, the bottom PE of an N-row column emits its own result first, then the results from the rows above, one per cycle for N cycles. The top PE ties psum_in_vld=0.

## Timing
- Forwarding latency: 1 cycle, no bubbles; throughput 1 operand pair per cycle.
- acc_out reflects a fire sampled at edge k from edge k onward, i.e. visible in cycle k+1.
- psum_out / psum_vld are valid 1 cycle after the load edge. In a chain, row r (counted from the bottom, 0-based) appears at the bottom output r+1 cycles after load.
- load on consecutive cycles: each load recaptures acc. A second load one cycle later therefore emits the single-product/zero value and overwrites the shifting data; the drain sequencer must space loads ≥ N cycles apart.
- Reset mid-accumulation or mid-drain: all state is lost immediately and asynchronously. Drain resumes only on the next load.
- ovf is sticky until clear or load.

## Test plan
- Reset, then (a,b) = (2,1),(2,2),(2,3),(3,1),(3,2),(3,3) with both valids high, one pair per cycle → acc_out 2,6,12,15,21,30. out_a/out_b echo each input 1 cycle later. ovf=0.
- Same stream with in_b_vld=0 on the (2,3) cycle → final acc_out=24. out_b_vld low for exactly one cycle, 1 cycle later.
- SIGNED=1, DATA_W=8: (-128)×(-128) then (-3)×5 → acc_out 16384, then 16369.
- SATURATE=1, ACC_W=16, unsigned: five 255×255 fires → acc_out 65535 and ovf=1 after the 2nd fire. clear → acc 0, ovf 0. SATURATE=0 with the same stimulus → acc_out wraps modulo 2^16 and ovf=1.
- 3-deep column, accumulators 7/11/13 (top→bottom), load pulse → bottom psum_out = 13, 11, 7 on consecutive cycles with psum_vld high for exactly 3 cycles. A fire of 2×2 coincident with load → bottom acc = 4 afterwards.
- Assert reset_n=0 asynchronously mid-drain and mid-accumulation → all outputs 0 before the next clk edge. Release → accumulation restarts from 0.
